// File: rtl/ysyx_23060201_ifu_sram.sv
// rtl/ysyx_23060201_ifu_sram.sv - instruction fetch SRAM with fixed response latency
// One outstanding fetch; read data captured at accept, byte-masked write port usable in any state.
module ysyx_23060201_ifu_sram #(
  parameter int          DEPTH   = 4096,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        wen,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];

  logic [31:0] roff, woff;
  logic        rd_ok, wr_ok;
  logic [AW-1:0] rd_idx, wr_idx;

  // Offsets are 33-bit compared so BASE+4*DEPTH cannot wrap.
  assign roff   = req_addr - BASE;
  assign woff   = waddr - BASE;
  assign rd_ok  = (req_addr >= BASE) && ({1'b0, roff} < SPAN) && (req_addr[1:0] == 2'b00);
  assign wr_ok  = (waddr >= BASE) && ({1'b0, woff} < SPAN);
  assign rd_idx = roff[AW+1:2];
  assign wr_idx = woff[AW+1:2];

  always_ff @(posedge clk) begin
    if (wen && wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            // mem read here sees the pre-edge contents, so a same-edge write is not observed.
            rsp_data  <= rd_ok ? mem[rd_idx] : 32'd0;
            rsp_err   <= !rd_ok;
            req_ready <= 1'b0;
            if (LATENCY <= 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ysyx_23060201_ifu_sram.md
YSYX_23060201_IFU_SRAM -- requirements
Module: ysyx_23060201_IFU_SRAM

Interface
REQ-001 Parameter DEPTH, default 4096, number of 32-bit words in the array.
REQ-002 Parameter BASE, default 32'h8000_0000, byte address of word 0.
REQ-003 Parameter LATENCY, default 1, legal range 1..15, cycles from request accept to response valid.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 req_valid  input  1  fetch request present.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_addr  input  32  fetch byte address.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  initiator accepts response.
REQ-011 rsp_data  output  32  fetched instruction word.
REQ-012 rsp_err  output  1  access fault for this response.
REQ-013 wen  input  1  preload/store write enable.
REQ-014 waddr  input  32  write byte address; bits [1:0] ignored.
REQ-015 wdata  input  32  write data.
REQ-016 wstrb  input  4  byte enables; bit i writes wdata[8i+7:8i].

Function
REQ-017 The FSM SHALL have states IDLE, WAIT and RESP; at most one transaction is outstanding.
REQ-018 req_ready SHALL be registered and high only in IDLE.
REQ-019 Accept occurs on a rising edge where req_valid=1 and req_ready=1; req_addr is sampled at that edge.
REQ-020 On accept: LATENCY=1 -> RESP; LATENCY>1 -> WAIT with a down-counter loaded to LATENCY-2.
REQ-021 In WAIT, the counter decrements every cycle; at count 0 the next edge moves to RESP.
REQ-022 rsp_valid SHALL be high exactly in RESP, first high LATENCY cycles after the accept edge.
REQ-023 In RESP, rsp_data and rsp_err SHALL be held stable until the edge where rsp_ready=1, which returns the FSM to IDLE.
REQ-024 The next request can be accepted no earlier than one cycle after response handshake (no bypass; peak throughput 1 per LATENCY+1 cycles).
REQ-025 Index = (req_addr - BASE) >> 2; access is valid iff BASE <= req_addr < BASE+4*DEPTH and req_addr[1:0]==0.
REQ-026 Invalid access SHALL give rsp_err=1 and rsp_data=0 at the same latency; valid access gives rsp_err=0.
REQ-027 Read data SHALL be captured at the accept edge, so a write to the same word on the accept edge returns old data, and later writes do not alter the pending response.
REQ-028 Writes SHALL be performed on any edge with wen=1 in any FSM state, byte-masked by wstrb; out-of-range waddr is silently dropped.
REQ-029 Changes on req_valid/req_addr outside IDLE SHALL be ignored.

Reset
REQ-030 While rst=0: state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, counter=0, applied asynchronously.
REQ-031 req_ready SHALL rise on the first rising edge after rst returns to 1.
REQ-032 Reset during WAIT or RESP SHALL discard the transaction; no response is issued afterward.
REQ-033 Array contents SHALL NOT be reset; only the write port modifies them.

Verification
REQ-034 LATENCY=1, preload word 0 = 32'h0000_0413, request 32'h8000_0000 with rsp_ready=1 -> rsp_valid on the cycle after accept, rsp_data=32'h0000_0413, rsp_err=0, req_ready high the cycle after handshake.
REQ-035 LATENCY=4, request 32'h8000_0010 -> rsp_valid first high exactly 4 cycles after accept, never earlier.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid/req_addr and writing the same word -> rsp_valid, rsp_data unchanged, no second accept.
REQ-037 Requests to 32'h8000_0002 and 32'h7FFF_FFFC and BASE+4*DEPTH -> rsp_err=1, rsp_data=0 each.
REQ-038 Write wstrb=4'b0010, wdata=32'hAABB_CCDD over word 32'h1122_3344 -> later read returns 32'h1122_CC44.
REQ-039 Assert rst=0 mid-WAIT (LATENCY=4) -> outputs zero immediately; after release no stale rsp_valid, req_ready returns high.
